// File: rtl/xtal_startup_sequencer.sv
// xtal_startup_sequencer: powers, qualifies and supervises the crystal clock.
// Define XTAL_DIFF_CHECK_EN to also qualify the XtalClkN rectifier leg.
module xtal_startup_sequencer #(
  parameter int STARTUP_CYCLES = 1024,
  parameter int WINDOW_CYCLES  = 256,
  parameter int MIN_EDGES      = 60,
  parameter int MAX_EDGES      = 68,
  parameter int GOOD_WINDOWS   = 4,
  parameter int RETRY_CYCLES   = 4096,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       Start,
  input  logic       Stop,
  input  logic       XtalClkP,
`ifdef XTAL_DIFF_CHECK_EN
  input  logic       XtalClkN,
`endif
  output logic       XtalEnable,
  output logic       HighDrive,
  output logic       ClockSel,
  output logic       ClockGood,
  output logic       Fault,
  output logic [1:0] RetryCount
);

  localparam int TMAX = (STARTUP_CYCLES > RETRY_CYCLES) ?
                        STARTUP_CYCLES : RETRY_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int GW = $clog2(GOOD_WINDOWS + 1);

  localparam logic [TW-1:0] T_START = TW'(STARTUP_CYCLES - 1);
  localparam logic [TW-1:0] T_RETRY = TW'(RETRY_CYCLES - 1);
  localparam logic [WW-1:0] W_LAST  = WW'(WINDOW_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST  = GW'(GOOD_WINDOWS - 1);
  localparam logic [15:0]   E_MIN   = 16'(MIN_EDGES);
  localparam logic [15:0]   E_MAX   = 16'(MAX_EDGES);
  localparam logic [1:0]    R_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_OFF,
    S_POWERUP,
    S_QUALIFY,
    S_RUN,
    S_FAULT,
    S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [WW-1:0] wtmr_q, wtmr_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [15:0]   cntp_q, cntp_d;
  logic [2:0]    syncp_q;
  logic          pulse_p;

  logic xen_q, xen_d;
  logic hd_q, hd_d;
  logic sel_q, sel_d;
  logic cgood_q, cgood_d;
  logic fault_q, fault_d;

  logic win_run;
  logic win_end;
  logic win_clr;
  logic win_good;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] c,
    input logic        p
  );
    return (p && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  function automatic logic in_range(input logic [15:0] c);
    return (c >= E_MIN) && (c <= E_MAX);
  endfunction

  // [0],[1] synchronize, [2] holds the previous level for edge detect
  assign pulse_p = syncp_q[1] & ~syncp_q[2];

  assign win_run = (state_q == S_QUALIFY) || (state_q == S_RUN);
  assign win_end = win_run && (wtmr_q == W_LAST);
  assign win_clr = win_end ||
                   ((state_q == S_POWERUP) && (tmr_q == T_START));

  always_comb begin
    wtmr_d = wtmr_q;
    cntp_d = cntp_q;
    if (win_clr) begin
      wtmr_d = '0;
      cntp_d = {15'd0, pulse_p};
    end else if (win_run) begin
      wtmr_d = wtmr_q + WW'(1);
      cntp_d = sat_inc(cntp_q, pulse_p);
    end
  end

`ifdef XTAL_DIFF_CHECK_EN
  logic [2:0]  syncn_q;
  logic        pulse_n;
  logic [15:0] cntn_q, cntn_d;
  logic [15:0] cdiff;

  assign pulse_n = syncn_q[1] & ~syncn_q[2];
  assign cdiff   = (cntp_q >= cntn_q) ? cntp_q - cntn_q
                                      : cntn_q - cntp_q;
  // a dead leg shows as a count mismatch even when both are in range
  assign win_good = in_range(cntp_q) && in_range(cntn_q) &&
                    (cdiff <= 16'd1);

  always_comb begin
    cntn_d = cntn_q;
    if (win_clr) begin
      cntn_d = {15'd0, pulse_n};
    end else if (win_run) begin
      cntn_d = sat_inc(cntn_q, pulse_n);
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      syncn_q <= '0;
      cntn_q  <= '0;
    end else begin
      syncn_q <= {syncn_q[1:0], XtalClkN};
      cntn_q  <= cntn_d;
    end
  end
`else
  assign win_good = in_range(cntp_q);
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    gcnt_d  = gcnt_q;
    retry_d = retry_q;
    if ((state_q != S_OFF) && Stop) begin
      state_d = S_OFF;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (Start && !Stop) begin
            state_d = S_POWERUP;
            tmr_d   = '0;
            retry_d = '0;
          end
        end
        S_POWERUP: begin
          if (tmr_q == T_START) begin
            state_d = S_QUALIFY;
            gcnt_d  = '0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_QUALIFY: begin
          if (win_end) begin
            if (!win_good) begin
              state_d = S_FAULT;
              tmr_d   = '0;
            end else if (gcnt_q == G_LAST) begin
              state_d = S_RUN;
            end else begin
              gcnt_d = gcnt_q + GW'(1);
            end
          end
        end
        S_RUN: begin
          if (win_end && !win_good) begin
            state_d = S_FAULT;
            tmr_d   = '0;
          end
        end
        S_FAULT: begin
          if (tmr_q == T_RETRY) begin
            if (retry_q < R_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = S_POWERUP;
              tmr_d   = '0;
            end else begin
              state_d = S_LOCKOUT;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_LOCKOUT: begin
          state_d = S_LOCKOUT;
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
  end

  // outputs decoded from the next state so they change on the entry edge
  always_comb begin
    xen_d   = (state_d == S_POWERUP) || (state_d == S_QUALIFY) ||
              (state_d == S_RUN);
    hd_d    = (state_d == S_POWERUP);
    sel_d   = (state_d == S_RUN);
    cgood_d = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT) || (state_d == S_LOCKOUT);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_OFF;
      tmr_q   <= '0;
      wtmr_q  <= '0;
      gcnt_q  <= '0;
      retry_q <= '0;
      cntp_q  <= '0;
      syncp_q <= '0;
      xen_q   <= 1'b0;
      hd_q    <= 1'b0;
      sel_q   <= 1'b0;
      cgood_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      wtmr_q  <= wtmr_d;
      gcnt_q  <= gcnt_d;
      retry_q <= retry_d;
      cntp_q  <= cntp_d;
      syncp_q <= {syncp_q[1:0], XtalClkP};
      xen_q   <= xen_d;
      hd_q    <= hd_d;
      sel_q   <= sel_d;
      cgood_q <= cgood_d;
      fault_q <= fault_d;
    end
  end

  assign XtalEnable = xen_q;
  assign HighDrive  = hd_q;
  assign ClockSel   = sel_q;
  assign ClockGood  = cgood_q;
  assign Fault      = fault_q;
  assign RetryCount = retry_q;

endmodule

// File: doc/xtal_startup_sequencer.md
Name: xtal_startup_sequencer

Overview:
Sequences and supervises the crystal oscillator and its differential rectifier that produce the ClockP/ClockN pair. The block runs on an always-available reference clock. It powers the oscillator with high drive, waits out crystal startup, and measures the crystal frequency in fixed windows. It then hands the system clock mux over to the crystal, keeps monitoring it, and falls back with bounded retries on loss of clock.

Parameters:
STARTUP_CYCLES, 1024, reference cycles held in high-drive power-up before any measurement.
WINDOW_CYCLES, 256, reference cycles per frequency-measurement window.
MIN_EDGES, 60, minimum XtalClkP rising edges per window for a good window (inclusive).
MAX_EDGES, 68, maximum XtalClkP rising edges per window for a good window (inclusive).
GOOD_WINDOWS, 4, consecutive good windows required before ClockGood.
RETRY_CYCLES, 4096, reference cycles in FAULT before restarting power-up.
MAX_RETRIES, 3, restarts allowed before LOCKOUT.

Ports:
Clock  input  1  reference clock (RC), all logic on rising edge.
ResetN  input  1  asynchronous active-low reset; asserts asynchronously, released synchronously externally.
Start  input  1  level-sampled; 1 in OFF begins sequencing.
Stop  input  1  1 in any state except OFF returns to OFF next cycle; Stop has priority over Start.
XtalClkP  input  1  rectified crystal clock, asynchronous to Clock.
XtalEnable  output  1  oscillator/op-amp supply enable.
HighDrive  output  1  boosted drive, only in POWERUP.
ClockSel  output  1  1 = system mux selects crystal clock.
ClockGood  output  1  crystal verified and selected.
Fault  output  1  set in FAULT and LOCKOUT.
RetryCount  output  2  restarts consumed, saturating.

Behaviour:
- Reset: state OFF. All outputs 0. Counters 0.
- XtalClkP passes through a 2-flop synchronizer plus an edge register. Rising-edge pulses are counted into a 16-bit saturating EdgeCnt, cleared at each window start.
- Window timer counts 0..WINDOW_CYCLES-1. At terminal count: good = MIN_EDGES <= EdgeCnt <= MAX_EDGES. EdgeCnt restarts at 0, and an edge on the terminal cycle counts into the new window.
- OFF: outputs 0. Start=1 -> POWERUP; RetryCount cleared.
- POWERUP: XtalEnable=1, HighDrive=1. Timer runs STARTUP_CYCLES, then -> QUALIFY; window timer and GoodCnt cleared.
- QUALIFY: XtalEnable=1. Good window increments GoodCnt; at GoodCnt==GOOD_WINDOWS -> RUN. Bad window -> FAULT.
- RUN: XtalEnable=1, ClockSel=1, ClockGood=1, registered and asserted in the same cycle as entry. Monitoring continues; any bad window -> FAULT.
- Latency: with Start sampled at edge 0, ClockGood rises at edge 1+STARTUP_CYCLES+GOOD_WINDOWS*WINDOW_CYCLES.
- FAULT: ClockSel=0 and ClockGood=0 on entry cycle. XtalEnable=0, Fault=1. Waits RETRY_CYCLES. Then, if RetryCount<MAX_RETRIES: RetryCount+1 and -> POWERUP. Else -> LOCKOUT.
- LOCKOUT: Fault=1, XtalEnable=0. Leaves only via Stop (-> OFF, Fault cleared) or ResetN.
- Stop while Start=1: OFF is held; re-entry from OFF requires Stop=0.
- ResetN asserted mid-operation: immediate OFF with all outputs 0; no glitch on ClockSel beyond the reset edge.
- A stuck XtalClkP (0 edges) or overspeed (EdgeCnt>MAX_EDGES, saturating at 65535) is a bad window.

Optional Feature:
XTAL_DIFF_CHECK_EN.
- Defined: adds input XtalClkN (1 bit) with an identical synchronizer and a second counter. A window is good only if both counts are in range and |EdgeCntP-EdgeCntN| <= 1. This catches a dead rectifier leg.
- Undefined: no XtalClkN port; P-only check as above.

Test Plan:
- Params STARTUP=16, WINDOW=32, MIN=7, MAX=9, GOOD=2, RETRY=20, MAX_RETRIES=2. XtalClkP = Clock/4 (8 edges/window). Start at edge 0 -> HighDrive 1 for edges 1-16; ClockGood=ClockSel=1 at edge 81; Fault=0.
- Same setup, XtalClkP held at 0 -> FAULT at edge 49. XtalEnable=0 for 20 cycles. Two retries, RetryCount 1 then 2, then LOCKOUT with Fault=1.
- In RUN, XtalClkP changed to Clock/2 (16 edges) -> ClockSel falls on the next window boundary; state FAULT; then recovers through POWERUP once Clock/4 is restored.
- In QUALIFY, Start=1 and Stop=1 together -> OFF next edge, all outputs 0, held while Start stays 1.
- ResetN pulsed low in RUN mid-window -> all outputs 0 asynchronously. After release with Start=1, full sequence repeats with ClockGood at +81.
- With XTAL_DIFF_CHECK_EN defined: XtalClkN=Clock/4 but stopped after 4 edges -> bad window, FAULT at edge 49. With XtalClkN matching -> ClockGood at edge 81.
